// File: rtl/video_timing_pkg.sv
// Shared types and preset tables for the multi-mode video timing generator.
// Timing fields are fixed at TW bits; the generator casts them to its CNT_W.
package video_timing_pkg;

    localparam int unsigned TW = 12;

    typedef enum logic [1:0] {
        MODE_640X480   = 2'd0,
        MODE_800X600   = 2'd1,
        MODE_1280X720  = 2'd2,
        MODE_1920X1080 = 2'd3
    } mode_e;

    // Polarity bit: 1 = sync pulse drives high, 0 = sync pulse drives low.
    typedef struct packed {
        logic [TW-1:0] h_active;
        logic [TW-1:0] h_fp;
        logic [TW-1:0] h_sync;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] v_active;
        logic [TW-1:0] v_fp;
        logic [TW-1:0] v_sync;
        logic [TW-1:0] v_bp;
        logic          hs_pol;
        logic          vs_pol;
    } timing_t;

    localparam timing_t T_640X480 = '{
        h_active: 12'd640,  h_fp: 12'd16,  h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480,  v_fp: 12'd10,  v_sync: 12'd2,  v_bp: 12'd33,
        hs_pol: 1'b0, vs_pol: 1'b0};

    localparam timing_t T_800X600 = '{
        h_active: 12'd800,  h_fp: 12'd40,  h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600,  v_fp: 12'd1,   v_sync: 12'd4,   v_bp: 12'd23,
        hs_pol: 1'b1, vs_pol: 1'b1};

    localparam timing_t T_1280X720 = '{
        h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
        v_active: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,  v_bp: 12'd20,
        hs_pol: 1'b1, vs_pol: 1'b1};

    localparam timing_t T_1920X1080 = '{
        h_active: 12'd1920, h_fp: 12'd88,  h_sync: 12'd44, h_bp: 12'd148,
        v_active: 12'd1080, v_fp: 12'd4,   v_sync: 12'd5,  v_bp: 12'd36,
        hs_pol: 1'b1, vs_pol: 1'b1};

    function automatic timing_t get_timing(input mode_e m);
        case (m)
            MODE_640X480:   return T_640X480;
            MODE_800X600:   return T_800X600;
            MODE_1280X720:  return T_1280X720;
            default:        return T_1920X1080;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Bus between the timing generator (master) and pixel sources (slave).
// VTG_PREFETCH_EN adds the one-cycle-early pre_de/pre_x/pre_y signals.
interface video_timing_if #(
    parameter int unsigned CNT_W = 12
);
    logic [1:0]       mode_sel;
    logic             hs;
    logic             vs;
    logic             de;
    logic [CNT_W-1:0] active_x;
    logic [CNT_W-1:0] active_y;
    logic             frame_start;
    logic             line_start;
    logic [1:0]       mode_cur;

`ifdef VTG_PREFETCH_EN
    logic             pre_de;
    logic [CNT_W-1:0] pre_x;
    logic [CNT_W-1:0] pre_y;

    modport master (
        input  mode_sel,
        output hs, vs, de, active_x, active_y, frame_start, line_start, mode_cur,
        output pre_de, pre_x, pre_y
    );
    modport slave (
        output mode_sel,
        input  hs, vs, de, active_x, active_y, frame_start, line_start, mode_cur,
        input  pre_de, pre_x, pre_y
    );
`else
    modport master (
        input  mode_sel,
        output hs, vs, de, active_x, active_y, frame_start, line_start, mode_cur
    );
    modport slave (
        output mode_sel,
        input  hs, vs, de, active_x, active_y, frame_start, line_start, mode_cur
    );
`endif

endinterface

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counter pair with end-of-frame flag.
module video_timing_cnt #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] h_total_i,
    input  logic [CNT_W-1:0] v_total_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             eof_o
);
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_wrap, v_wrap;

    always_comb begin
        h_wrap = (h_q == h_total_i - CNT_W'(1));
        v_wrap = (v_q == v_total_i - CNT_W'(1));
        eof_o  = h_wrap && v_wrap;
        h_d    = h_wrap ? '0 : h_q + CNT_W'(1);
        v_d    = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/video_timing_gen.sv
// Multi-mode raster timing generator: 640x480, 800x600, 1280x720, 1920x1080 @60.
// Define VTG_PREFETCH_EN to add pre_de/pre_x/pre_y, one cycle ahead of de/active_x/active_y.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned MODE_RST = 2
) (
    input  logic           clk,
    input  logic           rst,
    video_timing_if.master bus
);
    mode_e            mode_q, mode_d, mode_in, mode_cur_q;
    timing_t          tm;
    logic [CNT_W-1:0] h, v, h_total, v_total;
    logic [CNT_W-1:0] h_act, hs_start, hs_end, v_act, vs_start, vs_end;
    logic             eof, in_de, in_hs, in_vs;
    logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, ls_q, ls_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

    always_comb begin
        case (bus.mode_sel)
            2'd0:    mode_in = MODE_640X480;
            2'd1:    mode_in = MODE_800X600;
            2'd2:    mode_in = MODE_1280X720;
            2'd3:    mode_in = MODE_1920X1080;
            default: mode_in = mode_e'(2'(MODE_RST));
        endcase
    end

    // In reset the table follows the incoming mode so hs/vs idle at its polarity.
    assign tm       = get_timing(rst ? mode_in : mode_q);
    assign h_act    = CNT_W'(tm.h_active);
    assign hs_start = CNT_W'(tm.h_active + tm.h_fp);
    assign hs_end   = CNT_W'(tm.h_active + tm.h_fp + tm.h_sync);
    assign h_total  = CNT_W'(tm.h_active + tm.h_fp + tm.h_sync + tm.h_bp);
    assign v_act    = CNT_W'(tm.v_active);
    assign vs_start = CNT_W'(tm.v_active + tm.v_fp);
    assign vs_end   = CNT_W'(tm.v_active + tm.v_fp + tm.v_sync);
    assign v_total  = CNT_W'(tm.v_active + tm.v_fp + tm.v_sync + tm.v_bp);

    video_timing_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .h_total_i (h_total),
        .v_total_i (v_total),
        .h_o       (h),
        .v_o       (v),
        .eof_o     (eof)
    );

    always_comb begin
        in_de  = (h < h_act) && (v < v_act);
        in_hs  = (h >= hs_start) && (h < hs_end);
        // vs edges line up with the hs leading edge, not with the line start.
        in_vs  = ((v == vs_start) && (h >= hs_start)) ||
                 ((v > vs_start) && (v < vs_end)) ||
                 ((v == vs_end) && (h < hs_start));
        mode_d = eof ? mode_in : mode_q;
        de_d   = in_de;
        x_d    = in_de ? h : '0;
        y_d    = in_de ? v : '0;
        hs_d   = in_hs ? tm.hs_pol : ~tm.hs_pol;
        vs_d   = in_vs ? tm.vs_pol : ~tm.vs_pol;
        fs_d   = (h == '0) && (v == '0);
        ls_d   = (h == '0) && (v < v_act);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= mode_in;
            mode_cur_q <= mode_in;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            hs_q       <= ~tm.hs_pol;
            vs_q       <= ~tm.vs_pol;
            fs_q       <= 1'b0;
            ls_q       <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            mode_cur_q <= mode_q;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
            ls_q       <= ls_d;
        end
    end

    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.de          = de_q;
    assign bus.active_x    = x_q;
    assign bus.active_y    = y_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
    assign bus.mode_cur    = mode_cur_q;

`ifdef VTG_PREFETCH_EN
    assign bus.pre_de = !rst && in_de;
    assign bus.pre_x  = bus.pre_de ? h : '0;
    assign bus.pre_y  = bus.pre_de ? v : '0;
`endif

endmodule
